// File: rtl/regfile_wb_ctrl_if.sv
// Writeback/issue bus between the execute/memory stages, decode and the
// register-file writeback controller.
interface regfile_wb_ctrl_if #(
    parameter int N = 16
);
    logic         a_valid;
    logic         a_ready;
    logic [2:0]   a_addr;
    logic [N-1:0] a_data;
    logic         b_valid;
    logic         b_ready;
    logic [2:0]   b_addr;
    logic [N-1:0] b_data;
    logic         issue_valid;
    logic         issue_wr;
    logic [2:0]   issue_waddr;
    logic [2:0]   issue_raddr1;
    logic [2:0]   issue_raddr2;
    logic         issue_stall;
    logic         rf_write_enable;
    logic [2:0]   rf_write_addr;
    logic [N-1:0] rf_write_data;
    logic [7:0]   pending;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  issue_valid, issue_wr, issue_waddr, issue_raddr1, issue_raddr2,
        output a_ready, b_ready, issue_stall,
        output rf_write_enable, rf_write_addr, rf_write_data, pending
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output issue_valid, issue_wr, issue_waddr, issue_raddr1, issue_raddr2,
        input  a_ready, b_ready, issue_stall,
        input  rf_write_enable, rf_write_addr, rf_write_data, pending
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter (ALU vs memory) plus RAW/WAW pending scoreboard for the 8-entry RF.
// Optional feature: WB_RR_ARB_EN selects round-robin conflicts; otherwise memory always wins.
module regfile_wb_ctrl #(
    parameter int N = 16
) (
    input logic         clk,
    input logic         rst,
    regfile_wb_ctrl_if.slave wb
);
    logic         a_win;
    logic         a_grant;
    logic         b_grant;
    logic         accept;
    logic         issue_acc;
    logic [2:0]   sel_addr;
    logic [N-1:0] sel_data;

    logic         we_q,   we_d;
    logic [2:0]   wa_q,   wa_d;
    logic [N-1:0] wd_q,   wd_d;
    logic [7:0]   pend_q, pend_d;

`ifdef WB_RR_ARB_EN
    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;
    grant_e last_q, last_d;

    assign a_win = (last_q == GRANT_B);

    always_comb begin
        last_d = last_q;
        if (wb.a_valid && wb.b_valid)
            last_d = a_win ? GRANT_A : GRANT_B;
    end

    always_ff @(posedge clk) begin
        if (!rst) last_q <= GRANT_B;
        else      last_q <= last_d;
    end
`else
    assign a_win = 1'b0;
`endif

    assign a_grant   = wb.a_valid & (~wb.b_valid | a_win);
    assign b_grant   = wb.b_valid & (~wb.a_valid | ~a_win);
    assign accept    = a_grant | b_grant;
    assign sel_addr  = a_grant ? wb.a_addr : wb.b_addr;
    assign sel_data  = a_grant ? wb.a_data : wb.b_data;

    // Stall looks only at registered pending; a same-cycle clear does not unblock.
    assign wb.issue_stall = wb.issue_valid & (pend_q[wb.issue_raddr1] | pend_q[wb.issue_raddr2]
                                              | (wb.issue_wr & pend_q[wb.issue_waddr]));
    assign issue_acc      = wb.issue_valid & ~wb.issue_stall;

    always_comb begin
        we_d   = accept;
        wa_d   = wa_q;
        wd_d   = wd_q;
        pend_d = pend_q;
        if (accept) begin
            wa_d = sel_addr;
            wd_d = sel_data;
        end
        // Clear first so a same-register set in the same cycle wins.
        if (we_q)
            pend_d[wa_q] = 1'b0;
        if (issue_acc && wb.issue_wr)
            pend_d[wb.issue_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q   <= 1'b0;
            wa_q   <= 3'd0;
            wd_q   <= '0;
            pend_q <= 8'h00;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    assign wb.a_ready         = a_grant;
    assign wb.b_ready         = b_grant;
    assign wb.rf_write_enable = we_q;
    assign wb.rf_write_addr   = wa_q;
    assign wb.rf_write_data   = wd_q;
    assign wb.pending         = pend_q;
endmodule
